// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains one frame from the ADC->FFT FIFO onto a valid/ready stream via a 2-entry skid buffer.
// Define FIFO_FRAME_READER_TWOS_COMP_EN to convert offset-binary samples to signed two's complement.
module fifo_frame_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_LEN   = 8192,
  parameter int START_LEVEL = 1024,
  parameter int LEVEL_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   fifo_rd_en,
  input  logic [10:0]            fifo_rd_data,
  input  logic                   fifo_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underflow_err,
  output logic [13:0]            sample_cnt
);
  typedef enum logic [1:0] {IDLE, ARM, STREAM, DONE} state_t;
  localparam logic [13:0] FLEN = 14'(FRAME_LEN);
  localparam logic [13:0] LAST = 14'(FRAME_LEN - 1);
  state_t                r_state, w_next;
  logic [13:0]           r_issued, r_cnt;
  logic                  r_inflight, r_uf;
  logic [1:0]            r_occ, w_wr_idx;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1, w_sample;
  logic                  w_start, w_hs, w_more;
  assign w_start  = start & (r_state == IDLE) & !abort;
  assign w_hs     = m_tvalid & m_tready & !abort;
  assign w_more   = r_issued < FLEN;
  assign w_wr_idx = r_occ - 2'(w_hs);
  always_comb begin
    w_sample = '0;
`ifdef FIFO_FRAME_READER_TWOS_COMP_EN
    w_sample = {{(DATA_WIDTH-10){~fifo_rd_data[10]}}, fifo_rd_data[9:0]};
`else
    w_sample[10:0] = fifo_rd_data;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (abort) w_next = IDLE;
    else
      unique case (r_state)
        IDLE:    w_next = start ? ARM : IDLE;
        ARM:     w_next = (fifo_rd_level >= LEVEL_WIDTH'(START_LEVEL)) ? STREAM : ARM;
        STREAM:  w_next = (w_hs & m_tlast) ? DONE : STREAM;
        default: w_next = IDLE;
      endcase
  end
  // Pop-aware occupancy lets a read issue every cycle while the head drains.
  always_comb begin
    busy       = r_state != IDLE;
    frame_done = r_state == DONE;
    fifo_rd_en = (r_state == STREAM) & !abort & !fifo_empty & w_more
               & ((w_wr_idx + 2'(r_inflight)) < 2'd2);
  end
  assign m_tvalid      = r_occ != 2'd0;
  assign m_tdata       = r_buf0;
  assign m_tlast       = m_tvalid & (r_cnt == LAST);
  assign sample_cnt    = r_cnt;
  assign underflow_err = r_uf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_issued   <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_uf       <= 1'b0;
      r_occ      <= '0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_issued   <= w_start ? '0 : r_issued + 14'(fifo_rd_en);
      r_cnt      <= w_start ? '0 : r_cnt + 14'(w_hs);
      r_uf       <= w_start ? 1'b0 : r_uf | ((r_state == STREAM) & w_more & fifo_empty);
      if (abort) r_occ <= '0;
      else begin
        if (w_hs) r_buf0 <= r_buf1;
        if (r_inflight && w_wr_idx == 2'd0) r_buf0 <= w_sample;
        if (r_inflight && w_wr_idx != 2'd0) r_buf1 <= w_sample;
        r_occ <= w_wr_idx + 2'(r_inflight);
      end
    end
endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Read-side consumer of the ADC-to-FFT asynchronous sample FIFO; runs entirely in the FFT clock domain.
- Waits until enough samples are buffered, then drains exactly FRAME_LEN samples.
- Presents the samples on a valid/ready stream to the FFT core, with last-sample marking and frame status.
- Hides the FIFO's 1-cycle read latency behind a 2-entry skid buffer so back-pressure never loses or duplicates a sample.

Parameters:
- DATA_WIDTH, 16, output sample width; must be >= 11.
- FRAME_LEN, 8192, samples per frame; range 2..8192.
- START_LEVEL, 1024, minimum FIFO read level before draining begins; range 1..FRAME_LEN.
- LEVEL_WIDTH, 14, width of the FIFO read-level input.

Ports:
- clk  in  1  FFT-domain clock; same clock as the FIFO read port.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse that arms one frame capture; ignored unless in IDLE.
- abort  in  1  1-cycle pulse that cancels the current frame from any state.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  11  FIFO read data; valid 1 cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_level  in  LEVEL_WIDTH  FIFO read water level.
- m_tdata  out  DATA_WIDTH  output sample.
- m_tvalid  out  1  output sample valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  marks sample FRAME_LEN-1 of the frame.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  1-cycle pulse when the last sample is accepted.
- underflow_err  out  1  sticky; FIFO went empty mid-frame.
- sample_cnt  out  14  number of samples accepted by downstream in the current frame.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; skid buffer empty; read-issue counter 0.
- FSM states and transitions:
  - IDLE -> ARM on start.
  - ARM -> STREAM when fifo_rd_level >= START_LEVEL.
  - STREAM -> DONE when the last sample handshakes (m_tvalid & m_tready & m_tlast).
  - DONE -> IDLE after 1 cycle; frame_done is high during DONE.
- Read issue (STREAM only): fifo_rd_en = !fifo_empty & (issued < FRAME_LEN) & (skid occupancy + reads in flight < 2).
  - A read issued at cycle n loads the skid buffer at cycle n+1.
  - Never issue a read to an empty FIFO. Never issue more than FRAME_LEN reads per frame.
- Output stream:
  - m_tvalid = skid buffer non-empty; m_tdata = head entry.
  - Handshake occurs when m_tvalid & m_tready. Data is held stable while m_tvalid & !m_tready.
  - Simultaneous buffer load and pop on the same cycle is legal; occupancy is unchanged.
  - Sustained throughput is 1 sample/cycle when m_tready=1 and the FIFO is non-empty.
  - Latency from entering STREAM to the first m_tvalid is 2 cycles.
- Counters:
  - sample_cnt increments on each handshake and clears on start.
  - m_tlast = m_tvalid & (sample_cnt == FRAME_LEN-1).
- Data conversion: default is zero-extension, {(DATA_WIDTH-11) zeros, fifo_rd_data}.
- Underflow:
  - In STREAM with issued < FRAME_LEN, fifo_empty=1 sets underflow_err.
  - The frame continues; gaps appear as m_tvalid low.
  - underflow_err clears only on start or reset.
- Abort:
  - In any state, returns to IDLE next cycle; fifo_rd_en=0 that cycle.
  - The skid buffer is flushed and any in-flight read result is discarded (not loaded).
  - m_tvalid goes low; frame_done is not pulsed; sample_cnt holds its value.
  - abort takes priority over start and over a same-cycle last handshake.
- Reset mid-frame clears everything immediately (asynchronous); no partial output.

Optional Feature:
- Macro: FIFO_FRAME_READER_TWOS_COMP_EN.
- When defined: the ADC sample is treated as offset-binary and converted to signed two's complement by inverting bit 10, then sign-extending to DATA_WIDTH.
  - 11'h400 -> 0; 11'h000 -> -1024 (16'hFC00); 11'h7FF -> +1023 (16'h03FF).
- When undefined: zero-extension as described in Behaviour; there is no sign logic.

Test Plan:
1. FRAME_LEN=16, START_LEVEL=8, FIFO preloaded with 16 samples 0..15, m_tready=1, start pulse -> m_tvalid for 16 consecutive cycles with m_tdata 0..15, m_tlast only on 15, frame_done 1 cycle later, underflow_err=0.
2. Same stimulus with m_tready toggling 1,0,0,1 repeatedly -> all 16 samples delivered in order with no duplicates, m_tdata stable while stalled, fifo_rd_en count = 16.
3. FIFO holds 5 samples, level held at 5 < START_LEVEL=8 -> remains in ARM with fifo_rd_en=0; raise level to 8 -> streaming begins 2 cycles later.
4. FIFO runs empty after sample 9 of 16, refilled 20 cycles later -> underflow_err=1 sticky, m_tvalid gap, samples 10..15 still delivered, frame_done pulses, next start clears underflow_err.
5. abort asserted while a read is in flight at sample 6 -> IDLE next cycle, m_tvalid=0, no frame_done, the in-flight sample is not output; a new start with sample_cnt cleared behaves as in test 1.
6. With FIFO_FRAME_READER_TWOS_COMP_EN defined, inputs 11'h000, 11'h400, 11'h7FF -> m_tdata 16'hFC00, 16'h0000, 16'h03FF; without the macro -> 16'h0000, 16'h0400, 16'h07FF.
